// File: rtl/fft_engine_serial_if.sv
// Bundle of control, sample-stream, result-stream and twiddle-ROM signals for
// the serial FFT engine. The engine is the slave; the surrounding system is the master.
//
// Handshakes: a word moves on a falling clk edge where valid and ready are both 1.
// While valid is high and ready is low, the sender holds data stable.
interface fft_engine_serial_if #(
  parameter int LOG2_N = 6,
  parameter int DW     = 16,
  parameter int TW     = 10
);
  logic                     start;
  logic                     inverse;
  logic                     scale_en;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DW-1:0]     in_re;
  logic signed [DW-1:0]     in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic signed [DW-1:0]     out_re;
  logic signed [DW-1:0]     out_im;
  logic        [LOG2_N-2:0] tw_addr;
  logic signed [TW-1:0]     tw_re;
  logic signed [TW-1:0]     tw_im;
  logic                     busy;
  logic                     done;
  logic                     ovf;
  logic        [1:0]        dbg_state;

  modport slave (
    input  start, inverse, scale_en, in_valid, in_re, in_im, out_ready, tw_re, tw_im,
    output in_ready, out_valid, out_last, out_re, out_im, tw_addr, busy, done, ovf, dbg_state
  );

  modport master (
    output start, inverse, scale_en, in_valid, in_re, in_im, out_ready, tw_re, tw_im,
    input  in_ready, out_valid, out_last, out_re, out_im, tw_addr, busy, done, ovf, dbg_state
  );
endinterface

// File: rtl/fft_engine_serial.sv
// Serial in-place radix-2 DIT FFT: loads samples in bit-reversed order, runs one
// butterfly per clock against an external twiddle ROM, then streams bins in natural order.
module fft_engine_serial #(
  parameter int N_PTS  = 64,
  parameter int LOG2_N = 6,
  parameter int DW     = 16,
  parameter int TW     = 10
) (
  input logic                clk,
  input logic                rst,
  fft_engine_serial_if.slave bus
);

  localparam int HALF = N_PTS / 2;
  localparam int IW   = DW + TW + 2;

  localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N_PTS - 1);
  localparam logic [LOG2_N-2:0] BF_LAST  = (LOG2_N-1)'(HALF - 1);
  localparam logic [LOG2_N-1:0] ST_LAST  = LOG2_N'(LOG2_N - 1);

  localparam logic signed [IW-1:0] MAXV = {{(IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [LOG2_N-1:0] stage_q, stage_d;
  logic [LOG2_N-2:0] bfly_q, bfly_d;
  logic              inv_q, inv_d;
  logic              scale_q, scale_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic signed [DW-1:0] mem_re [N_PTS];
  logic signed [DW-1:0] mem_im [N_PTS];

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] n);
    logic [LOG2_N-1:0] r;
    for (int i = 0; i < LOG2_N; i++) r[i] = n[LOG2_N-1-i];
    return r;
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > MAXV) return MAXV[DW-1:0];
    if (v < MINV) return MINV[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [IW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Butterfly addressing for the current (stage, butterfly) pair
  logic [LOG2_N-1:0] b_ext, one_s, j_idx, top_addr, bot_addr, tw_sh;
  logic [LOG2_N-2:0] tw_idx;

  always_comb begin
    b_ext    = {1'b0, bfly_q};
    one_s    = LOG2_N'(1) << stage_q;
    j_idx    = b_ext & (one_s - LOG2_N'(1));
    top_addr = ((b_ext >> stage_q) << (stage_q + LOG2_N'(1))) | j_idx;
    bot_addr = top_addr | one_s;
    tw_sh    = ST_LAST - stage_q;
    tw_idx   = (LOG2_N-1)'(j_idx << tw_sh);
  end

  logic signed [IW-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [IW-1:0] t_re, t_im, s_re, s_im, d_re, d_im;
  logic signed [DW-1:0] top_re_n, top_im_n, bot_re_n, bot_im_n;
  logic                 bf_hit;

  always_comb begin
    a_re = IW'(mem_re[top_addr]);
    a_im = IW'(mem_im[top_addr]);
    b_re = IW'(mem_re[bot_addr]);
    b_im = IW'(mem_im[bot_addr]);
    w_re = IW'(bus.tw_re);
    w_im = inv_q ? -IW'(bus.tw_im) : IW'(bus.tw_im);
    // Twiddles carry TW-2 fraction bits; drop them by truncation
    t_re = (b_re * w_re - b_im * w_im) >>> (TW - 2);
    t_im = (b_re * w_im + b_im * w_re) >>> (TW - 2);
    s_re = a_re + t_re;
    s_im = a_im + t_im;
    d_re = a_re - t_re;
    d_im = a_im - t_im;
    if (scale_q) begin
      s_re = s_re >>> 1;
      s_im = s_im >>> 1;
      d_re = d_re >>> 1;
      d_im = d_im >>> 1;
    end
    top_re_n = sat(s_re);
    top_im_n = sat(s_im);
    bot_re_n = sat(d_re);
    bot_im_n = sat(d_im);
    bf_hit   = out_of_range(s_re) | out_of_range(s_im) |
               out_of_range(d_re) | out_of_range(d_im);
  end

  logic load_fire, unload_fire;
  assign load_fire   = (state_q == S_LOAD) && bus.in_valid;
  assign unload_fire = (state_q == S_UNLOAD) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    inv_d   = inv_q;
    scale_d = scale_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          inv_d   = bus.inverse;
          scale_d = bus.scale_en;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_fire) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
          end else begin
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (bf_hit) ovf_d = 1'b1;
        if (bfly_q == BF_LAST) begin
          bfly_d = '0;
          if (stage_q == ST_LAST) begin
            state_d = S_UNLOAD;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            stage_d = stage_q + LOG2_N'(1);
          end
        end else begin
          bfly_d = bfly_q + (LOG2_N-1)'(1);
        end
      end
      S_UNLOAD: begin
        if (unload_fire) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      inv_q   <= 1'b0;
      scale_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      inv_q   <= inv_d;
      scale_q <= scale_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Sample memory holds no reset; its contents are meaningless until a LOAD completes
  always_ff @(negedge clk) begin
    if (rst) begin
      if (load_fire) begin
        mem_re[bitrev(cnt_q)] <= bus.in_re;
        mem_im[bitrev(cnt_q)] <= bus.in_im;
      end else if (state_q == S_COMPUTE) begin
        mem_re[top_addr] <= top_re_n;
        mem_im[top_addr] <= top_im_n;
        mem_re[bot_addr] <= bot_re_n;
        mem_im[bot_addr] <= bot_im_n;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_UNLOAD);
  assign bus.out_last  = (state_q == S_UNLOAD) && (cnt_q == CNT_LAST);
  assign bus.out_re    = (state_q == S_UNLOAD) ? mem_re[cnt_q] : '0;
  assign bus.out_im    = (state_q == S_UNLOAD) ? mem_im[cnt_q] : '0;
  assign bus.tw_addr   = (state_q == S_COMPUTE) ? tw_idx : '0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fft_engine_serial.sv
// Bench for fft_engine_serial (N=8): directed cases plus randomized transforms
// scored against an array-based fixed-point FFT model.
module tb_fft_engine_serial;

  localparam int N      = 8;
  localparam int LOG2_N = 3;
  localparam int DW     = 16;
  localparam int TW     = 10;
  localparam longint MAXI = 32767;
  localparam longint MINI = -32768;

  logic clk;
  logic rst;

  fft_engine_serial_if #(.LOG2_N(LOG2_N), .DW(DW), .TW(TW)) bus ();

  fft_engine_serial #(.N_PTS(N), .LOG2_N(LOG2_N), .DW(DW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- twiddle ROM ----------------
  int rom_re [N/2];
  int rom_im [N/2];

  initial begin
    real pi, ang;
    pi = 3.14159265358979;
    for (int k = 0; k < N/2; k++) begin
      ang = 2.0 * pi * k / N;
      rom_re[k] = $rtoi($floor(256.0 * $cos(ang) + 0.5));
      rom_im[k] = $rtoi($floor(-256.0 * $sin(ang) + 0.5));
    end
  end

  always_comb begin
    bus.tw_re = TW'(rom_re[bus.tw_addr]);
    bus.tw_im = TW'(rom_im[bus.tw_addr]);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*DW-1:0] exp_q[$];
  bit exp_ovf;

  int in_re_a  [N];
  int in_im_a  [N];
  int out_re_a [N];
  int out_im_a [N];
  int compute_cycles;
  bit run_ok;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int brev(input int n);
    int r = 0;
    for (int i = 0; i < LOG2_N; i++) if (n[i]) r |= 1 << (LOG2_N - 1 - i);
    return r;
  endfunction

  function automatic longint clip(input longint v);
    if (v > MAXI) return MAXI;
    if (v < MINI) return MINI;
    return v;
  endfunction

  task automatic model_fft(input bit inv, input bit scl);
    longint re [N];
    longint im [N];
    longint r4 [4];
    longint wr, wi, tr, ti, c;
    int half, t, bt, k;
    exp_ovf = 1'b0;
    for (int n = 0; n < N; n++) begin
      re[brev(n)] = in_re_a[n];
      im[brev(n)] = in_im_a[n];
    end
    for (int s = 0; s < LOG2_N; s++) begin
      half = 1 << s;
      for (int g = 0; g < N; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          t  = g + j;
          bt = t + half;
          k  = j * N / (2 * half);
          wr = rom_re[k];
          wi = inv ? -rom_im[k] : rom_im[k];
          tr = (re[bt] * wr - im[bt] * wi) >>> (TW - 2);
          ti = (re[bt] * wi + im[bt] * wr) >>> (TW - 2);
          r4[0] = re[t] + tr;
          r4[1] = im[t] + ti;
          r4[2] = re[t] - tr;
          r4[3] = im[t] - ti;
          for (int q = 0; q < 4; q++) begin
            if (scl) r4[q] = r4[q] >>> 1;
            c = clip(r4[q]);
            if (c != r4[q]) exp_ovf = 1'b1;
            r4[q] = c;
          end
          re[t]  = r4[0];
          im[t]  = r4[1];
          re[bt] = r4[2];
          im[bt] = r4[3];
        end
      end
    end
    for (int m = 0; m < N; m++) exp_q.push_back({DW'(re[m]), DW'(im[m])});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input bit inv, input bit scl);
    @(posedge clk);
    bus.start    = 1'b1;
    bus.inverse  = inv;
    bus.scale_en = scl;
    @(posedge clk);
    bus.start    = 1'b0;
    bus.inverse  = 1'($urandom_range(0, 1));
    bus.scale_en = 1'($urandom_range(0, 1));
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic do_load();
    int n = 0;
    int cyc = 0;
    bit v;
    while (n < N && cyc < 1000) begin
      v = ($urandom_range(0, 3) != 0);
      bus.in_valid = v;
      bus.in_re    = DW'(in_re_a[n]);
      bus.in_im    = DW'(in_im_a[n]);
      bus.start    = 1'($urandom_range(0, 1));
      if (v && bus.in_ready) n++;
      cyc++;
      @(posedge clk);
    end
    bus.start = 1'b0;
    if (n < N) begin
      check("load_timeout", 0, 1);
      run_ok = 1'b0;
    end
  endtask

  task automatic do_compute();
    int cyc = 0;
    while (!bus.out_valid && cyc < 5000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_re    = DW'($urandom);
      bus.in_im    = DW'($urandom);
      cyc++;
      @(posedge clk);
    end
    bus.in_valid = 1'b0;
    compute_cycles = cyc;
    if (!bus.out_valid) begin
      check("compute_timeout", 0, 1);
      run_ok = 1'b0;
    end
  endtask

  task automatic do_unload(input int rmode);
    int m = 0;
    int p = 0;
    int cyc = 0;
    bit r;
    while (m < N && cyc < 5000) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = ((p % 4) == 0) || ((p % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      p++;
      bus.out_ready = r;
      check("out_valid", bus.out_valid, 1);
      if (r) begin
        out_re_a[m] = int'(bus.out_re);
        out_im_a[m] = int'(bus.out_im);
        check("out_last", bus.out_last, (m == N - 1));
        m++;
      end
      cyc++;
      @(posedge clk);
    end
    bus.out_ready = 1'b0;
    if (m < N) begin
      check("unload_timeout", 0, 1);
      run_ok = 1'b0;
    end else begin
      check("done_pulse", bus.done, 1);
      check("busy_after_done", bus.busy, 0);
      check("out_valid_idle", bus.out_valid, 0);
      @(posedge clk);
      check("done_clear", bus.done, 0);
    end
  endtask

  task automatic run_fft(input bit inv, input bit scl, input int rmode);
    logic [2*DW-1:0] e;
    run_ok = 1'b1;
    model_fft(inv, scl);
    do_start(inv, scl);
    do_load();
    if (run_ok) do_compute();
    if (run_ok) begin
      check("compute_cycles", compute_cycles, LOG2_N * N / 2);
      do_unload(rmode);
    end
    if (run_ok) begin
      for (int m = 0; m < N; m++) begin
        e = exp_q.pop_front();
        check("bin_re", out_re_a[m], longint'($signed(e[2*DW-1:DW])));
        check("bin_im", out_im_a[m], longint'($signed(e[DW-1:0])));
      end
      check("ovf_model", bus.ovf, exp_ovf);
    end
    exp_q.delete();
  endtask

  task automatic fill(input int re_val, input int im_val);
    for (int n = 0; n < N; n++) begin
      in_re_a[n] = re_val;
      in_im_a[n] = im_val;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int amp;
    bus.start     = 1'b0;
    bus.inverse   = 1'b0;
    bus.scale_en  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_re", bus.out_re, 0);
    check("rst_out_im", bus.out_im, 0);
    check("rst_tw_addr", bus.tw_addr, 0);
    rst = 1'b1;
    @(posedge clk);

    // impulse, forward, unscaled: flat spectrum
    fill(0, 0);
    in_re_a[0] = 100;
    run_fft(1'b0, 1'b0, 0);
    for (int m = 0; m < N; m++) begin
      check("impulse_re", out_re_a[m], 100);
      check("impulse_im", out_im_a[m], 0);
    end
    check("impulse_ovf", bus.ovf, 0);

    // DC input, scaled: energy only in bin 0
    fill(100, 0);
    run_fft(1'b0, 1'b1, 0);
    check("dc_cycles", compute_cycles, 12);
    for (int m = 0; m < N; m++) begin
      check("dc_re", out_re_a[m], (m == 0) ? 100 : 0);
      check("dc_im", out_im_a[m], 0);
    end

    // forward then inverse round trip, both scaled
    fill(0, 0);
    in_re_a[1] = 800;
    run_fft(1'b0, 1'b1, 0);
    for (int m = 0; m < N; m++) begin
      in_re_a[m] = out_re_a[m];
      in_im_a[m] = out_im_a[m];
    end
    run_fft(1'b1, 1'b1, 0);
    for (int m = 0; m < N; m++) begin
      amp = (m == 1) ? 100 : 0;
      check("rt_re_tol", (out_re_a[m] >= amp - 1) && (out_re_a[m] <= amp + 1), 1);
      check("rt_im_tol", (out_im_a[m] >= -1) && (out_im_a[m] <= 1), 1);
    end

    // full-scale DC, unscaled: saturation
    fill(32767, 0);
    run_fft(1'b0, 1'b0, 0);
    check("sat_bin0", out_re_a[0], 32767);
    check("sat_ovf", bus.ovf, 1);

    // back-pressure 1,0,0,1,... on the result stream
    for (int n = 0; n < N; n++) begin
      in_re_a[n] = int'($urandom_range(0, 4000)) - 2000;
      in_im_a[n] = int'($urandom_range(0, 4000)) - 2000;
    end
    run_fft(1'b0, 1'b1, 1);

    // reset pulse in the middle of COMPUTE
    fill(0, 0);
    in_re_a[2] = 500;
    do_start(1'b0, 1'b0);
    run_ok = 1'b1;
    do_load();
    repeat (5) @(posedge clk);
    check("mid_tw_busy", bus.busy, 1);
    rst = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_tw_addr", bus.tw_addr, 0);
    for (int n = 0; n < N; n++) begin
      in_re_a[n] = int'($urandom_range(0, 2000)) - 1000;
      in_im_a[n] = int'($urandom_range(0, 2000)) - 1000;
    end
    run_fft(1'b0, 1'b0, 2);

    // randomized transforms against the model
    for (int it = 0; it < 8; it++) begin
      amp = (it % 2 == 1) ? 32767 : 3000;
      for (int n = 0; n < N; n++) begin
        in_re_a[n] = int'($urandom_range(0, 2 * amp)) - amp;
        in_im_a[n] = int'($urandom_range(0, 2 * amp)) - amp;
      end
      run_fft(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
